// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared segment constants for the score display
// Purpose: segment bit order, 7-segment patterns for digits 0-9, dash and
//          blank, and the digit-enable helper used by the scanner.
// Ports:   none (package).
package score_display_pkg;

  // A 7-bit segment pattern is ordered {g,f,e,d,c,b,a}; 0 lights a segment.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low enable for the digit selected by idx (idx 0 = ones).
  function automatic logic [3:0] digit_mask(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/score_display_if.sv
// rtl/score_display_if.sv - score input and LED drive bundle
// Purpose: groups the score/blink inputs and the multiplexed LED outputs.
// Ports:   points[15:0] packed BCD score, blink level,
//          an[3:0] digit enables, seg[6:0] {g..a}, dp (all active-low).
interface score_display_if;
  logic [15:0] points;
  logic        blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output points, output blink, input an, input seg, input dp);
  modport slave  (input points, input blink, output an, output seg, output dp);
endinterface

// File: rtl/score_display_bcd_to_seg.sv
// rtl/score_display_bcd_to_seg.sv - BCD nibble to active-low 7-segment decode
// Purpose: combinational decode; nibbles above 9 show a dash.
// Ports:   bcd[3:0] in, seg[6:0] out {g,f,e,d,c,b,a}, active-low.
module bcd_to_seg
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - 4-digit multiplexed score display with blink
// Purpose: scans a frame-coherent snapshot of a BCD score onto a 4-digit
//          common-anode display, blanks leading zeros, flashes on blink.
// Ports:   clk, rst (sync, active-high);
//          bus.points/bus.blink in, bus.an/bus.seg/bus.dp out (registered).
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst,
  score_display_if.slave      bus
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [15:0]      snapshot;
  logic [FR_W-1:0]  frame_cnt;
  logic             blink_phase;

  logic       tick;
  logic       frame_end;
  logic [3:0] nibble;
  logic       blank_digit;
  logic       dark;
  logic [6:0] dec_seg;

  assign tick      = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx == 2'd3);
  assign dark      = bus.blink && blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= 2'd0;
      snapshot    <= 16'h0000;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
      // Only sample the score between frames so every frame is coherent.
      if (frame_end) snapshot <= bus.points;
      if (!bus.blink) begin
        frame_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (frame_end) begin
        if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Digit select and leading-zero blanking for the digit being scanned.
  always_comb begin
    nibble      = snapshot[3:0];
    blank_digit = 1'b0;
    case (idx)
      2'd0: nibble = snapshot[3:0];
      2'd1: begin
        nibble      = snapshot[7:4];
        blank_digit = (snapshot[15:4] == 12'h000);
      end
      2'd2: begin
        nibble      = snapshot[11:8];
        blank_digit = (snapshot[15:8] == 8'h00);
      end
      default: begin
        nibble      = snapshot[15:12];
        blank_digit = (snapshot[15:12] == 4'h0);
      end
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (nibble),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.an  <= AN_OFF;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      bus.dp <= 1'b1;
      if (dark || blank_digit) begin
        bus.an  <= AN_OFF;
        bus.seg <= SEG_BLANK;
      end else begin
        bus.an  <= digit_mask(idx);
        bus.seg <= dec_seg;
      end
    end
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is lit (minimum 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (minimum 1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port points  input  16  packed BCD score; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-006 SHALL have port blink  input  1  level; 1 flashes the whole display (game over).
REQ-007 SHALL have port an  output  4  digit enables, active-low; an[0] is the ones digit.
REQ-008 SHALL have port seg  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
REQ-009 SHALL have port dp  output  1  decimal point, active-low; constant 1 (off).

Function
REQ-010 SHALL run a divider counting 0..REFRESH_DIV-1 and wrapping to 0; the terminal count is "tick".
REQ-011 SHALL hold a 2-bit digit index; it advances 0->1->2->3->0 on each tick.
REQ-012 SHALL load a 16-bit snapshot from points on the tick that moves the index from 3 to 0, so each frame shows one coherent value.
REQ-013 SHALL ignore points changes between snapshots.
REQ-014 SHALL register an, seg and dp; they reflect the current index and snapshot one cycle after the index changes.
REQ-015 SHALL drive exactly one an bit low per cycle when not blanked: an = ~(1 << index).
REQ-016 SHALL decode digits 0-9 through the standard 7-segment table.
REQ-017 SHALL show any BCD nibble above 9 as a dash (segment g only, seg = 7'b0111111).
REQ-018 SHALL apply leading-zero blanking:
- thousands blank if it is 0;
- hundreds blank if thousands and hundreds are 0;
- tens blank if thousands, hundreds and tens are 0;
- ones is never blanked.
REQ-019 SHALL drive a blanked digit with an = 4'b1111 and seg = 7'h7F.
REQ-020 SHALL count completed frames (index 3->0) in a frame counter.
REQ-021 SHALL toggle blink_phase and clear the frame counter when the frame counter reaches BLINK_FRAMES-1 at a frame end.
REQ-022 SHALL hold an = 4'b1111 and seg = 7'h7F while blink = 1 and blink_phase = 1; blink_phase 0 displays normally.
REQ-023 SHALL clear blink_phase and the frame counter on the cycle after blink is seen low, so display resumes within 1 cycle.
REQ-024 SHALL take the new snapshot when a points change and a frame-end tick occur in the same cycle.

Reset
REQ-025 SHALL reset to: divider 0, index 0, snapshot 16'h0000, frame counter 0, blink_phase 0, an 4'b1111, seg 7'h7F, dp 1.
REQ-026 SHALL return every register to its REQ-025 value on the next edge when rst is asserted mid-frame, regardless of blink or points.
REQ-027 SHALL display snapshot 0 (ones digit "0") after reset until the first frame end.

Structure
REQ-028 SHALL place the segment pattern constants (digits 0-9, dash, blank) and segment bit order in the shared game package.
REQ-029 SHALL implement the nibble-to-segment decode as combinational sub-module bcd_to_seg (4-bit in, 7-bit active-low out, dash for >9), instantiated once.

Verification
REQ-030 SHALL check reset and scan: REFRESH_DIV=4; rst 1 cycle, points=16'h1234 -> after reset an=1111/seg=7F for 1 cycle, "0" on an=1110, then after the first frame end digits 4,3,2,1 on an=1110,1101,1011,0111, each held 4 cycles.
REQ-031 SHALL check blanking: points=16'h0007 -> only an=1110 ever goes low with seg=7'b1111000 ("7"); the other slots are blank; points=16'h0000 -> "0" on the ones digit only.
REQ-032 SHALL check invalid BCD: points=16'h00A5 -> tens slot shows dash 7'b0111111 and ones slot shows "5".
REQ-033 SHALL check snapshot coherence: points changes 16'h0099->16'h0100 mid-frame -> the rest of that frame still shows 99; the next frame shows 100.
REQ-034 SHALL check blink: BLINK_FRAMES=2, blink=1 -> 2 frames lit, 2 frames dark (an=1111), repeating; blink=0 -> normal scan 1 cycle later.
REQ-035 SHALL check reset mid-frame: rst asserted at index 2 with blink active -> all REQ-025 values on the next edge.
